ping_scheduler: RTL

Sequencing controller for the USBL acoustic transmit path. It accepts ping requests from up to N_CH transducer channels and grants them one at a time with round-robin fairness. For the granted channel it drives a gated square-wave carrier burst, then enforces a silent guard interval before the next ping, so no two transducers ever drive simultaneously. It sits between the mission/sequencing logic (requesters) and the transducer driver pins.

---
 rtl/ping_pkg.sv | 23 ++
 rtl/ping_scheduler_if.sv | 18 +
 rtl/carrier_burst.sv | 80 ++++++++
 rtl/ping_scheduler.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ping_pkg.sv
// ping_pkg -- shared state encoding and default carrier/guard constants for the acoustic blocks (rev 1.0)
`default_nettype none

package ping_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int DEF_HALF_PERIOD   = 625;
  localparam int DEF_BURST_PERIODS = 80;
  localparam int DEF_GUARD_CLKS    = 100_000_000;

  // Counter width for a 0..max_count-1 range, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ping_scheduler_if.sv
// ping_scheduler_if -- requester/transducer-side signals of the ping scheduler (rev 1.0)
`default_nettype none

interface ping_scheduler_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] req;
  logic            abort;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] tx;
  logic            busy;
  logic            done;

  modport master (output req, abort, input grant, tx, busy, done);
  modport slave  (input req, abort, output grant, tx, busy, done);
endinterface

`default_nettype wire

// File: rtl/carrier_burst.sv
// carrier_burst -- half-period/period counters for one square-wave burst; wave is the level for the next cycle (rev 1.0)
`default_nettype none

module carrier_burst
  import ping_pkg::*;
#(
  parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
  parameter int BURST_PERIODS = DEF_BURST_PERIODS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic wave,
  output logic last
);

  localparam int HW = cnt_width(HALF_PERIOD);
  localparam int PW = cnt_width(BURST_PERIODS);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(BURST_PERIODS - 1);

  logic [HW-1:0] half_cnt, half_nx;
  logic [PW-1:0] per_cnt, per_nx;
  logic          phase, phase_nx;
  logic          running, running_nx;
  logic          half_end;

  assign half_end = (half_cnt == HALF_LAST);
  // Current cycle is the final low-phase cycle of the burst.
  assign last     = running && !phase && half_end && (per_cnt == PER_LAST);
  assign wave     = phase_nx;

  always_comb begin
    half_nx    = half_cnt;
    per_nx     = per_cnt;
    phase_nx   = phase;
    running_nx = running;
    if (stop) begin
      half_nx    = '0;
      per_nx     = '0;
      phase_nx   = 1'b0;
      running_nx = 1'b0;
    end else if (start) begin
      half_nx    = '0;
      per_nx     = '0;
      phase_nx   = 1'b1;
      running_nx = 1'b1;
    end else if (running) begin
      if (!half_end) begin
        half_nx = half_cnt + 1'b1;
      end else if (last) begin
        running_nx = 1'b0;
      end else begin
        half_nx  = '0;
        phase_nx = ~phase;
        if (!phase) begin
          per_nx = per_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= '0;
      per_cnt  <= '0;
      phase    <= 1'b0;
      running  <= 1'b0;
    end else begin
      half_cnt <= half_nx;
      per_cnt  <= per_nx;
      phase    <= phase_nx;
      running  <= running_nx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ping_scheduler.sv
// ping_scheduler -- round-robin ping arbiter driving one gated carrier burst at a time, then a silent guard (rev 1.0)
`default_nettype none

module ping_scheduler
  import ping_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
  parameter int BURST_PERIODS = DEF_BURST_PERIODS,
  parameter int GUARD_CLKS    = DEF_GUARD_CLKS
) (
  input  logic              clk,
  input  logic              rst,
  ping_scheduler_if.slave   bus
);

  localparam int CW = cnt_width(N_CH);
  localparam int GW = cnt_width(GUARD_CLKS);
  localparam logic [CW-1:0] CH_LAST    = CW'(N_CH - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CLKS - 1);

  state_t          state;
  logic [CW-1:0]   cur_ch;
  logic [CW-1:0]   ptr;
  logic [GW-1:0]   guard_cnt;
  logic [N_CH-1:0] grant_q;
  logic [N_CH-1:0] tx_q;
  logic            busy_q;
  logic            done_q;

  logic [CW-1:0]   pick;
  logic [N_CH-1:0] pick_onehot;
  logic [N_CH-1:0] cur_onehot;
  logic            start;
  logic            stop;
  logic            wave;
  logic            last;

  // First requesting channel at or after ptr, wrapping at N_CH.
  function automatic logic [CW-1:0] rr_pick(input logic [N_CH-1:0] r, input logic [CW-1:0] p);
    logic [CW-1:0] idx;
    logic [CW-1:0] choice;
    logic          found;
    idx    = p;
    choice = p;
    found  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && r[idx]) begin
        choice = idx;
        found  = 1'b1;
      end
      idx = (idx == CH_LAST) ? '0 : idx + 1'b1;
    end
    return choice;
  endfunction

  assign pick        = rr_pick(bus.req, ptr);
  assign pick_onehot = N_CH'(1) << pick;
  assign cur_onehot  = N_CH'(1) << cur_ch;
  assign start       = (state == IDLE) && (|bus.req);
  assign stop        = (state == BURST) && bus.abort;

  carrier_burst #(
    .HALF_PERIOD   (HALF_PERIOD),
    .BURST_PERIODS (BURST_PERIODS)
  ) u_carrier (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .wave  (wave),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_ch    <= '0;
      ptr       <= '0;
      guard_cnt <= '0;
      grant_q   <= '0;
      tx_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      grant_q <= '0;
      tx_q    <= '0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= BURST;
            cur_ch  <= pick;
            ptr     <= (pick == CH_LAST) ? '0 : pick + 1'b1;
            grant_q <= pick_onehot;
            tx_q    <= pick_onehot;
            busy_q  <= 1'b1;
          end
        end
        BURST: begin
          if (bus.abort || last) begin
            state     <= GUARD;
            guard_cnt <= '0;
            done_q    <= (GUARD_LAST == '0);
          end else begin
            tx_q <= wave ? cur_onehot : '0;
          end
        end
        GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state     <= IDLE;
            guard_cnt <= '0;
            busy_q    <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
            done_q    <= ((guard_cnt + 1'b1) == GUARD_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

`default_nettype wire
